keypad_4x4_scan: RTL and testbench

KEYPAD_4X4_SCAN -- requirements
Module: keypad_4x4_scan

---
 rtl/keypad_4x4_scan.sv | 200 ++++++++++++++++++++
 tb/tb_keypad_4x4_scan.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/keypad_4x4_scan.sv
// 4x4 matrix keypad scanner: column drive, debounce FSM, accepted-key history.
// Define KEY_AUTOREPEAT_EN to emit repeat key_valid pulses while a key is held.
module keypad_4x4_scan #(
    parameter int SCAN_DIV  = 250000,
    parameter int DEB_SCANS = 4,
    parameter int RPT_SCANS = 40
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [3:0]  row,
    output logic [3:0]  col,
    output logic [3:0]  key_code,
    output logic        key_valid,
    output logic        key_down,
    output logic [15:0] digits
);
    localparam int DIV_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int DEB_W = $clog2(DEB_SCANS + 1);
    localparam logic [DIV_W-1:0] DIV_LAST   = DIV_W'(SCAN_DIV - 1);
    localparam logic [DEB_W-1:0] DEB_TARGET = DEB_W'(DEB_SCANS);
    localparam logic [DEB_W-1:0] DEB_ONE    = DEB_W'(1);

    typedef enum logic [1:0] {IDLE, DEBOUNCE, PRESSED, RELEASE} state_t;

    logic [3:0]       row_meta, row_sync;
    logic [DIV_W-1:0] div_cnt;
    logic [1:0]       col_idx;
    logic             hit_seen;
    logic [3:0]       hit_code;
    logic             sample, scan_done, row_any, scan_hit, cand_present, accept;
    logic [1:0]       row_first;
    logic [3:0]       scan_code;

    state_t           state, state_n;
    logic [3:0]       cand, cand_n, code_n;
    logic [DEB_W-1:0] deb_cnt, deb_n, deb_inc;
    logic             valid_n, down_n;
    logic [15:0]      digits_n;

    function automatic logic [3:0] key_map(input logic [1:0] r, input logic [1:0] c);
        case ({r, c})
            4'h0: key_map = 4'h1;  4'h1: key_map = 4'h2;  4'h2: key_map = 4'h3;  4'h3: key_map = 4'hA;
            4'h4: key_map = 4'h4;  4'h5: key_map = 4'h5;  4'h6: key_map = 4'h6;  4'h7: key_map = 4'hB;
            4'h8: key_map = 4'h7;  4'h9: key_map = 4'h8;  4'hA: key_map = 4'h9;  4'hB: key_map = 4'hC;
            4'hC: key_map = 4'h0;  4'hD: key_map = 4'hF;  4'hE: key_map = 4'hE;  default: key_map = 4'hD;
        endcase
    endfunction

    assign col       = ~(4'b0001 << col_idx);
    assign sample    = (div_cnt == DIV_LAST);
    assign scan_done = sample && (col_idx == 2'd3);

    // Earliest column wins; within a column the lowest row wins.
    always_comb begin
        row_any   = ~&row_sync;
        row_first = !row_sync[0] ? 2'd0 : !row_sync[1] ? 2'd1 : !row_sync[2] ? 2'd2 : 2'd3;
        scan_hit  = hit_seen | row_any;
        scan_code = hit_seen ? hit_code : key_map(row_first, col_idx);
        cand_present = scan_hit && (scan_code == cand);
        deb_inc   = (deb_cnt == DEB_TARGET) ? deb_cnt : deb_cnt + DEB_ONE;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            row_meta <= '0;
            row_sync <= '0;
            div_cnt  <= '0;
            col_idx  <= '0;
            hit_seen <= 1'b0;
            hit_code <= '0;
        end else begin
            row_meta <= row;
            row_sync <= row_meta;
            if (sample) begin
                div_cnt <= '0;
                col_idx <= col_idx + 2'd1;
                if (scan_done) begin
                    hit_seen <= 1'b0;
                    hit_code <= '0;
                end else if (!hit_seen && row_any) begin
                    hit_seen <= 1'b1;
                    hit_code <= key_map(row_first, col_idx);
                end
            end else begin
                div_cnt <= div_cnt + 1'b1;
            end
        end
    end

`ifdef KEY_AUTOREPEAT_EN
    localparam int RPT_W = $clog2(RPT_SCANS + 1);
    localparam logic [RPT_W-1:0] RPT_TARGET = RPT_W'(RPT_SCANS);
    logic [RPT_W-1:0] rpt_cnt, rpt_n, rpt_inc;
    assign rpt_inc = (rpt_cnt == RPT_TARGET) ? rpt_cnt : rpt_cnt + RPT_W'(1);
`endif

    always_comb begin
        state_n  = state;
        cand_n   = cand;
        deb_n    = deb_cnt;
        code_n   = key_code;
        valid_n  = 1'b0;
        down_n   = key_down;
        digits_n = digits;
        accept   = 1'b0;
`ifdef KEY_AUTOREPEAT_EN
        rpt_n    = rpt_cnt;
`endif
        if (scan_done) begin
            case (state)
                IDLE: if (scan_hit) begin
                    cand_n  = scan_code;
                    deb_n   = DEB_ONE;
                    state_n = DEBOUNCE;
                    accept  = (DEB_SCANS <= 1);
                end
                DEBOUNCE: begin
                    if (!scan_hit) begin
                        state_n = IDLE;
                        deb_n   = '0;
                    end else if (scan_code == cand) begin
                        deb_n  = deb_inc;
                        accept = (deb_inc >= DEB_TARGET);
                    end else begin
                        cand_n = scan_code;
                        deb_n  = DEB_ONE;
                    end
                end
                PRESSED: begin
                    if (!cand_present) begin
                        state_n = RELEASE;
                        deb_n   = DEB_ONE;
                    end
`ifdef KEY_AUTOREPEAT_EN
                    else if (rpt_inc >= RPT_TARGET) begin
                        valid_n  = 1'b1;
                        digits_n = {digits[11:0], key_code};
                        rpt_n    = '0;
                    end else begin
                        rpt_n = rpt_inc;
                    end
`endif
                end
                default: begin
                    // Key bounced back before release was confirmed: resume without a new pulse.
                    if (cand_present) begin
                        state_n = PRESSED;
                        deb_n   = '0;
`ifdef KEY_AUTOREPEAT_EN
                        rpt_n   = '0;
`endif
                    end else if (deb_inc >= DEB_TARGET) begin
                        state_n = IDLE;
                        deb_n   = '0;
                        down_n  = 1'b0;
                    end else begin
                        deb_n = deb_inc;
                    end
                end
            endcase
            if (accept) begin
                state_n  = PRESSED;
                deb_n    = '0;
                code_n   = cand_n;
                valid_n  = 1'b1;
                down_n   = 1'b1;
                digits_n = {digits[11:0], cand_n};
`ifdef KEY_AUTOREPEAT_EN
                rpt_n    = '0;
`endif
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            cand      <= '0;
            deb_cnt   <= '0;
            key_code  <= '0;
            key_valid <= 1'b0;
            key_down  <= 1'b0;
            digits    <= '0;
`ifdef KEY_AUTOREPEAT_EN
            rpt_cnt   <= '0;
`endif
        end else begin
            state     <= state_n;
            cand      <= cand_n;
            deb_cnt   <= deb_n;
            key_code  <= code_n;
            key_valid <= valid_n;
            key_down  <= down_n;
            digits    <= digits_n;
`ifdef KEY_AUTOREPEAT_EN
            rpt_cnt   <= rpt_n;
`endif
        end
    end
endmodule

// File: tb/tb_keypad_4x4_scan.sv
// Bench for keypad_4x4_scan: a keypad model closes row/column contacts, each
// expected press is queued and a monitor checks every key_valid pulse against it.
module tb_keypad_4x4_scan;
    localparam int SCAN_DIV  = 4;
    localparam int DEB_SCANS = 2;
    localparam int RPT_SCANS = 3;
    localparam int SCAN      = 4 * SCAN_DIV;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [3:0]  row;
    logic [3:0]  col;
    logic [3:0]  key_code;
    logic        key_valid;
    logic        key_down;
    logic [15:0] digits;

    logic [15:0] pressed = '0;  // bit r*4+c closes row r to column c
    logic [19:0] exp_q[$];      // {digits, key_code} expected at each key_valid
    logic [15:0] exp_digits = '0;
    int checks = 0;
    int errors = 0;
    int pulse_cnt = 0;
    int pulses_before;
    int lat;

    keypad_4x4_scan #(.SCAN_DIV(SCAN_DIV), .DEB_SCANS(DEB_SCANS), .RPT_SCANS(RPT_SCANS)) dut (
        .clk(clk), .rst(rst), .row(row), .col(col),
        .key_code(key_code), .key_valid(key_valid), .key_down(key_down), .digits(digits)
    );

    always #5 clk = ~clk;

    always_comb begin
        row = 4'hF;
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++)
                if (pressed[r*4+c] && !col[c]) row[r] = 1'b0;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic expect_press(input logic [3:0] code);
        exp_digits = {exp_digits[11:0], code};
        exp_q.push_back({exp_digits, code});
    endtask

    task automatic hold(input int scans);
        repeat (scans * SCAN) @(posedge clk);
        #1;
    endtask

    // Leaves the bench 1 time unit after the edge that starts column 0.
    task automatic align();
        logic [3:0] prev;
        logic found;
        prev = col;
        found = 1'b0;
        for (int i = 0; i < 4 * SCAN && !found; i++) begin
            @(posedge clk);
            #1;
            if (col == 4'b1110 && prev == 4'b0111) found = 1'b1;
            prev = col;
        end
        check("align_scan_start", found, 1'b1);
    endtask

    task automatic wait_valid(output int edges);
        edges = -1;
        for (int i = 1; i <= 8 * SCAN && edges < 0; i++) begin
            @(posedge clk);
            #1;
            if (key_valid) edges = i;
        end
    endtask

    task automatic do_reset();
        @(posedge clk);
        #1;
        rst = 1'b1;
        exp_digits = '0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    always @(negedge clk) begin : monitor
        logic [19:0] e;
        if (!rst && key_valid) begin
            pulse_cnt++;
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_key_valid: got key_code 0x%0h, expected no pulse", key_code);
            end else begin
                e = exp_q.pop_front();
                check("valid_key_code", key_code, e[3:0]);
                check("valid_digits", digits, e[19:4]);
                check("valid_key_down", key_down, 1'b1);
            end
        end
    end

    initial begin
        repeat (3) @(posedge clk);
        #1;
        check("reset_col", col, 4'b1110);
        check("reset_key_code", key_code, 4'h0);
        check("reset_key_valid", key_valid, 1'b0);
        check("reset_key_down", key_down, 1'b0);
        check("reset_digits", digits, 16'h0000);
        rst = 1'b0;

        // Key 6 held for exactly two scans.
        align();
        pressed[6] = 1'b1;
        expect_press(4'h6);
        hold(2);
        check("press6_latency_valid", key_valid, 1'b1);
        check("press6_key_code", key_code, 4'h6);
        check("press6_digits", digits, 16'h0006);
        check("press6_key_down", key_down, 1'b1);
        pressed = '0;
        hold(2);
        check("release6_key_down", key_down, 1'b0);
        check("release6_key_code_held", key_code, 4'h6);

        // One-scan glitch on key 1 must be rejected.
        pressed[0] = 1'b1;
        hold(1);
        pressed = '0;
        hold(3);
        check("glitch_digits", digits, exp_digits);
        check("glitch_key_code", key_code, 4'h6);
        check("glitch_key_down", key_down, 1'b0);

        // Sequence 1, 2, 3, A with full release between presses.
        pulses_before = pulse_cnt;
        pressed[0] = 1'b1; expect_press(4'h1); hold(2); pressed = '0; hold(2);
        pressed[1] = 1'b1; expect_press(4'h2); hold(2); pressed = '0; hold(2);
        pressed[2] = 1'b1; expect_press(4'h3); hold(2); pressed = '0; hold(2);
        pressed[3] = 1'b1; expect_press(4'hA); hold(2); pressed = '0; hold(2);
        check("seq_digits", digits, 16'h123A);
        check("seq_pulses", pulse_cnt - pulses_before, 4);

        // Keys 5 and 9 together; a one-scan drop-out must not re-trigger.
        pulses_before = pulse_cnt;
        pressed[5] = 1'b1; pressed[10] = 1'b1;
        expect_press(4'h5);
        hold(2);
        check("multi_key_code", key_code, 4'h5);
        pressed = '0;
        hold(1);
        check("bounce_key_down", key_down, 1'b1);
        pressed[5] = 1'b1; pressed[10] = 1'b1;
        hold(2);
        pressed = '0;
        hold(2);
        check("multi_pulses", pulse_cnt - pulses_before, 1);
        check("multi_key_down", key_down, 1'b0);

        // Reset while 8 is held, then re-detection from IDLE.
        pressed[9] = 1'b1;
        expect_press(4'h8);
        hold(2);
        check("press8_key_code", key_code, 4'h8);
        repeat (8) @(posedge clk);
        #1;
        rst = 1'b1;
        exp_digits = '0;
        #2;
        check("midreset_col", col, 4'b1110);
        check("midreset_key_code", key_code, 4'h0);
        check("midreset_key_valid", key_valid, 1'b0);
        check("midreset_key_down", key_down, 1'b0);
        check("midreset_digits", digits, 16'h0000);
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        expect_press(4'h8);
        wait_valid(lat);
        check("redetect_latency_edges", lat, 2 * SCAN);
        pressed = '0;
        hold(2);
        check("redetect_key_code", key_code, 4'h8);
        check("redetect_key_down", key_down, 1'b0);

        // F held for 2 + 9 scans.
        do_reset();
        align();
        pulses_before = pulse_cnt;
        pressed[13] = 1'b1;
`ifdef KEY_AUTOREPEAT_EN
        repeat (4) expect_press(4'hF);
`else
        expect_press(4'hF);
`endif
        hold(11);
        pressed = '0;
        hold(2);
`ifdef KEY_AUTOREPEAT_EN
        check("hold_f_pulses", pulse_cnt - pulses_before, 4);
        check("hold_f_digits", digits, 16'hFFFF);
`else
        check("hold_f_pulses", pulse_cnt - pulses_before, 1);
        check("hold_f_digits", digits, 16'h000F);
`endif
        check("hold_f_key_code", key_code, 4'hF);

        check("expected_queue_drained", exp_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
